// File: rtl/brubber_rom_loader.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | brubber_rom_loader                                                     |
// | Steers HPS ROM download bytes to per-region write ports, captures DIP  |
// | bytes and holds the core in reset until a complete, valid load.        |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module brubber_rom_loader #(
  parameter logic [17:0] ROM_SIZE       = 18'h18020,
  parameter int          RELEASE_CYCLES = 16
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [7:0]  ioctl_index,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic [16:0] rom_addr,
  output logic [7:0]  rom_data,
  output logic        cpu_we,
  output logic        snd_we,
  output logic        fg_we,
  output logic        bg_we,
  output logic        prom_we,
  output logic [7:0]  dsw1,
  output logic [7:0]  dsw2,
  output logic [7:0]  checksum,
  output logic        loaded,
  output logic        load_err,
  output logic        core_reset
);

  localparam logic [24:0] c_cpu_base  = 25'h00000;
  localparam logic [24:0] c_snd_base  = 25'h0C000;
  localparam logic [24:0] c_fg_base   = 25'h0E000;
  localparam logic [24:0] c_bg_base   = 25'h16000;
  localparam logic [24:0] c_prom_base = 25'h18000;
  localparam logic [24:0] c_rom_end   = 25'h18020;

  localparam int c_hold_w = (RELEASE_CYCLES > 1) ? $clog2(RELEASE_CYCLES) : 1;
  localparam logic [c_hold_w-1:0] c_hold_last = c_hold_w'(RELEASE_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_HOLD = 3'd2,
    ST_RUN  = 3'd3,
    ST_ERR  = 3'd4
  } state_t;

  state_t              r_state;
  logic                r_dl_q;
  logic [17:0]         r_count;
  logic                r_ovf;
  logic [c_hold_w-1:0] r_hold_cnt;

  logic        w_dl_rise;
  logic        w_dl_fall;
  logic        w_rom_idx;
  logic        w_dip_wr;
  logic        w_accept;
  logic        w_in_size;
  logic [4:0]  w_region;
  logic [16:0] w_base;
  logic [16:0] w_offset;
  logic [17:0] w_count_nx;
  logic [7:0]  w_cksum_nx;
  logic        w_ovf_nx;
  logic [17:0] w_count_eff;
  logic        w_ovf_eff;
  logic        w_load_ok;

  assign w_dl_rise = ioctl_download & ~r_dl_q;
  assign w_dl_fall = ~ioctl_download & r_dl_q;
  assign w_rom_idx = (ioctl_index == 8'd0);
  assign w_dip_wr  = ioctl_wr && (ioctl_index == 8'd254) && (ioctl_addr[24:1] == 24'd0);
  assign w_accept  = (r_state == ST_LOAD) && ioctl_wr && w_rom_idx;
  assign w_in_size = (ioctl_addr < {7'd0, ROM_SIZE});

  // Region order within w_region matches {cpu, snd, fg, bg, prom}.
  always_comb begin
    w_region = 5'b00000;
    w_base   = c_cpu_base[16:0];
    if (ioctl_addr < c_snd_base) begin
      w_region = 5'b10000;
      w_base   = c_cpu_base[16:0];
    end else if (ioctl_addr < c_fg_base) begin
      w_region = 5'b01000;
      w_base   = c_snd_base[16:0];
    end else if (ioctl_addr < c_bg_base) begin
      w_region = 5'b00100;
      w_base   = c_fg_base[16:0];
    end else if (ioctl_addr < c_prom_base) begin
      w_region = 5'b00010;
      w_base   = c_bg_base[16:0];
    end else if (ioctl_addr < c_rom_end) begin
      w_region = 5'b00001;
      w_base   = c_prom_base[16:0];
    end
  end

  assign w_offset   = ioctl_addr[16:0] - w_base;
  assign w_count_nx = (r_count == 18'h3FFFF) ? r_count : r_count + 18'd1;
  assign w_cksum_nx = checksum + ioctl_dout;
  assign w_ovf_nx   = r_ovf | ~w_in_size;

  // A byte landing on the same edge as the download falling edge counts toward completion.
  assign w_count_eff = w_accept ? w_count_nx : r_count;
  assign w_ovf_eff   = w_accept ? w_ovf_nx : r_ovf;
  assign w_load_ok   = (w_count_eff == ROM_SIZE) && !w_ovf_eff;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      // Held high so a download still active across reset is not seen as a new edge.
      r_dl_q     <= 1'b1;
      r_count    <= 18'd0;
      r_ovf      <= 1'b0;
      r_hold_cnt <= '0;
      rom_addr   <= 17'd0;
      rom_data   <= 8'd0;
      cpu_we     <= 1'b0;
      snd_we     <= 1'b0;
      fg_we      <= 1'b0;
      bg_we      <= 1'b0;
      prom_we    <= 1'b0;
      dsw1       <= 8'h00;
      dsw2       <= 8'h00;
      checksum   <= 8'd0;
      loaded     <= 1'b0;
      load_err   <= 1'b0;
      core_reset <= 1'b1;
    end else begin
      r_dl_q  <= ioctl_download;
      cpu_we  <= 1'b0;
      snd_we  <= 1'b0;
      fg_we   <= 1'b0;
      bg_we   <= 1'b0;
      prom_we <= 1'b0;

      if (w_dip_wr) begin
        if (ioctl_addr[0]) dsw2 <= ioctl_dout;
        else               dsw1 <= ioctl_dout;
      end

      if (w_accept) begin
        r_count  <= w_count_nx;
        checksum <= w_cksum_nx;
        r_ovf    <= w_ovf_nx;
        if (w_in_size) begin
          rom_addr <= w_offset;
          rom_data <= ioctl_dout;
          {cpu_we, snd_we, fg_we, bg_we, prom_we} <= w_region;
        end
      end

      case (r_state)
        ST_LOAD: begin
          if (w_dl_fall) begin
            if (w_load_ok) begin
              r_state    <= ST_HOLD;
              r_hold_cnt <= '0;
            end else begin
              r_state  <= ST_ERR;
              load_err <= 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (w_dl_rise && w_rom_idx) begin
            r_state <= ST_LOAD;
            r_count <= 18'd0;
            checksum <= 8'd0;
            r_ovf   <= 1'b0;
          end else if (r_hold_cnt == c_hold_last) begin
            r_state    <= ST_RUN;
            loaded     <= 1'b1;
            core_reset <= 1'b0;
          end else begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
          end
        end
        ST_IDLE, ST_RUN, ST_ERR: begin
          if (w_dl_rise && w_rom_idx) begin
            r_state    <= ST_LOAD;
            r_count    <= 18'd0;
            checksum   <= 8'd0;
            r_ovf      <= 1'b0;
            loaded     <= 1'b0;
            load_err   <= 1'b0;
            core_reset <= 1'b1;
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          loaded     <= 1'b0;
          load_err   <= 1'b0;
          core_reset <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
